// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: pipeline WB stream, long-unit handshake, scoreboard
// and the register-file write port, grouped for the arbiter and its driver.
interface wb_arbiter_if;
   logic        pipe_valid;
   logic [4:0]  pipe_addr;
   logic [31:0] pipe_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        lu_issue;
   logic [4:0]  lu_issue_addr;
   logic        stall_req;
   logic [31:0] busy_mask;
   logic        reg_write;
   logic [4:0]  write_addr;
   logic [31:0] write_data;

   modport slave (
      input  pipe_valid, pipe_addr, pipe_data,
      input  lu_valid, lu_addr, lu_data, lu_issue, lu_issue_addr,
      output lu_ready, stall_req, busy_mask,
      output reg_write, write_addr, write_data
   );

   modport master (
      output pipe_valid, pipe_addr, pipe_data,
      output lu_valid, lu_addr, lu_data, lu_issue, lu_issue_addr,
      input  lu_ready, stall_req, busy_mask,
      input  reg_write, write_addr, write_data
   );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: pipeline results win the register-file port, long-unit
// results queue in a FIFO and fill idle slots. Define WB_SCOREBOARD_EN for busy_mask.
module wb_arbiter #(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic         clk,
   input  logic         reset,
   wb_arbiter_if.slave  bus
);
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam int STV_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

   logic [4:0]       addr_mem [FIFO_DEPTH];
   logic [31:0]      data_mem [FIFO_DEPTH];

   logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
   logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [STV_W-1:0] starve_reg, starve_next;
   logic             reg_write_reg, reg_write_next;
   logic [4:0]       write_addr_reg, write_addr_next;
   logic [31:0]      write_data_reg, write_data_next;

   logic             fifo_empty, fifo_full, pipe_win, push, pop;
   logic [4:0]       head_addr;
   logic [31:0]      head_data;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == DEPTH_CNT);
   assign pipe_win   = bus.pipe_valid && (bus.pipe_addr != 5'd0);
   assign push       = bus.lu_valid && !fifo_full;
   assign pop        = !pipe_win && !fifo_empty;

   // The head is read straight into the output register, which acts as the RAM read register.
   assign head_addr  = addr_mem[rd_ptr_reg];
   assign head_data  = data_mem[rd_ptr_reg];

   assign bus.lu_ready   = !fifo_full;
   assign bus.stall_req  = fifo_full || (starve_reg == STARVE_MAX);
   assign bus.reg_write  = reg_write_reg;
   assign bus.write_addr = write_addr_reg;
   assign bus.write_data = write_data_reg;

   always_comb begin
      wr_ptr_next     = wr_ptr_reg;
      rd_ptr_next     = rd_ptr_reg;
      count_next      = count_reg;
      starve_next     = starve_reg;
      reg_write_next  = 1'b0;
      write_addr_next = 5'd0;
      write_data_next = 32'd0;

      if (push) wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_next = rd_ptr_reg + PTR_W'(1);

      case ({push, pop})
         2'b10:   count_next = count_reg + CNT_W'(1);
         2'b01:   count_next = count_reg - CNT_W'(1);
         default: count_next = count_reg;
      endcase

      if (pop || fifo_empty)
         starve_next = '0;
      else if (starve_reg != STARVE_MAX)
         starve_next = starve_reg + STV_W'(1);

      if (pipe_win) begin
         reg_write_next  = 1'b1;
         write_addr_next = bus.pipe_addr;
         write_data_next = bus.pipe_data;
      end else if (pop && (head_addr != 5'd0)) begin
         // An entry for register 0 is still consumed but produces an empty slot.
         reg_write_next  = 1'b1;
         write_addr_next = head_addr;
         write_data_next = head_data;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem[wr_ptr_reg] <= bus.lu_addr;
         data_mem[wr_ptr_reg] <= bus.lu_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg     <= '0;
         rd_ptr_reg     <= '0;
         count_reg      <= '0;
         starve_reg     <= '0;
         reg_write_reg  <= 1'b0;
         write_addr_reg <= 5'd0;
         write_data_reg <= 32'd0;
      end else begin
         wr_ptr_reg     <= wr_ptr_next;
         rd_ptr_reg     <= rd_ptr_next;
         count_reg      <= count_next;
         starve_reg     <= starve_next;
         reg_write_reg  <= reg_write_next;
         write_addr_reg <= write_addr_next;
         write_data_reg <= write_data_next;
      end
   end

`ifdef WB_SCOREBOARD_EN
   logic [31:0] busy_reg, busy_next;

   assign busy_next[0] = 1'b0;
   // Set is checked first so a re-issue on the popping edge keeps the bit.
   for (genvar gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (bus.lu_issue && (bus.lu_issue_addr == 5'(gi))) ||
                             (busy_reg[gi] && !(pop && (head_addr == 5'(gi))));
   end

   always_ff @(posedge clk) begin
      if (reset) busy_reg <= 32'd0;
      else       busy_reg <= busy_next;
   end

   assign bus.busy_mask = busy_reg;
`else
   logic unused_issue;
   assign unused_issue  = ^{bus.lu_issue, bus.lu_issue_addr};
   assign bus.busy_mask = 32'd0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized and directed bench for wb_arbiter against a queue-based
// transaction model of the write-back port.
module tb_wb_arbiter;
   localparam int DEPTH = 4;
   localparam int LIMIT = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   wb_arbiter_if bus();

   wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   ent_t        exp_q[$];
   int          exp_starve;
   logic        exp_wr;
   logic [4:0]  exp_addr;
   logic [31:0] exp_data;
   logic [31:0] exp_busy;
   int          total;
   int          bad;
   bit          comb_on;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", tag, got, want, $time);
      end
   endtask

   // One clock: drive inputs, check combinational flags before the edge,
   // advance the model, then check the registered outputs after the edge.
   task automatic cycle(input logic rst, input logic pv, input logic [4:0] pa,
                        input logic [31:0] pd, input logic lv, input logic [4:0] la,
                        input logic [31:0] ld, input logic li, input logic [4:0] lia);
      bit   full_now, was_empty, popped;
      ent_t e;
      reset             = rst;
      bus.pipe_valid    = pv;
      bus.pipe_addr     = pa;
      bus.pipe_data     = pd;
      bus.lu_valid      = lv;
      bus.lu_addr       = la;
      bus.lu_data       = ld;
      bus.lu_issue      = li;
      bus.lu_issue_addr = lia;
      @(negedge clk);
      full_now  = (exp_q.size() == DEPTH);
      was_empty = (exp_q.size() == 0);
      if (comb_on) begin
         check("lu_ready", 32'(bus.lu_ready), 32'(!full_now));
         check("stall_req", 32'(bus.stall_req), 32'(full_now || (exp_starve == LIMIT)));
      end
      if (rst) begin
         exp_q.delete();
         exp_starve = 0;
         exp_wr     = 1'b0;
         exp_addr   = 5'd0;
         exp_data   = 32'd0;
         exp_busy   = 32'd0;
      end else begin
         popped = 1'b0;
         e      = '0;
         if (pv && pa != 5'd0) begin
            exp_wr = 1'b1; exp_addr = pa; exp_data = pd;
         end else if (!was_empty) begin
            e      = exp_q.pop_front();
            popped = 1'b1;
            exp_wr = (e.a != 5'd0); exp_addr = e.a; exp_data = e.d;
         end else begin
            exp_wr = 1'b0;
         end
         if (popped || was_empty) exp_starve = 0;
         else if (exp_starve < LIMIT) exp_starve++;
         if (lv && !full_now) exp_q.push_back({la, ld});
`ifdef WB_SCOREBOARD_EN
         if (popped && e.a != 5'd0) exp_busy[e.a] = 1'b0;
         if (li && lia != 5'd0) exp_busy[lia] = 1'b1;
`endif
      end
      @(posedge clk);
      #1;
      check("reg_write", 32'(bus.reg_write), 32'(exp_wr));
      if (exp_wr) begin
         check("write_addr", 32'(bus.write_addr), 32'(exp_addr));
         check("write_data", bus.write_data, exp_data);
         $display("wb: r%0d <= %h", bus.write_addr, bus.write_data);
      end
      check("busy_mask", bus.busy_mask, exp_busy);
   endtask

   task automatic step(input logic pv, input logic [4:0] pa, input logic [31:0] pd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
      cycle(1'b0, pv, pa, pd, lv, la, ld, 1'b0, 5'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      comb_on = 1'b0;
      exp_q.delete();
      exp_starve = 0; exp_wr = 1'b0; exp_addr = 5'd0; exp_data = 32'd0; exp_busy = 32'd0;

      // Reset state
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      comb_on = 1'b1;
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      check("rst_addr", 32'(bus.write_addr), 32'd0);
      check("rst_data", bus.write_data, 32'd0);

      // Pipe only, and a dropped write to register 0
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
      check("pipe_data_const", bus.write_data, 32'hDEADBEEF);
      step(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'd0);
      check("pipe_r0_const", 32'(bus.reg_write), 32'd0);

      // Long-unit result into an idle slot: visible two cycles after handshake
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h12345678);
      check("lu_lat1_nowrite", 32'(bus.reg_write), 32'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("lu_addr_const", 32'(bus.write_addr), 32'd7);
      idle(1);

      // Fill the FIFO while the pipe holds the port, then drain in order
      for (int i = 0; i < 4; i++)
         step(1'b1, 5'(i + 1), $urandom, 1'b1, 5'(10 + i), $urandom);
      check("full_ready", 32'(bus.lu_ready), 32'd0);
      check("full_stall", 32'(bus.stall_req), 32'd1);
      idle(6);

      // Starvation: one entry blocked by a busy pipe
      step(1'b1, 5'd3, $urandom, 1'b1, 5'd20, 32'hCAFEF00D);
      for (int i = 0; i < 7; i++) step(1'b1, 5'd4, $urandom, 1'b0, 5'd0, 32'd0);
      check("starve7_stall", 32'(bus.stall_req), 32'd0);
      step(1'b1, 5'd4, $urandom, 1'b0, 5'd0, 32'd0);
      check("starve8_stall", 32'(bus.stall_req), 32'd1);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
      check("starve_pop_addr", 32'(bus.write_addr), 32'd20);
      check("starve_release", 32'(bus.stall_req), 32'd0);

      // Reset with three buffered entries and a live write
      for (int i = 0; i < 3; i++)
         step(1'b1, 5'(i + 1), $urandom, 1'b1, 5'(24 + i), $urandom);
      cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      check("midrst_write", 32'(bus.reg_write), 32'd0);
      check("midrst_ready", 32'(bus.lu_ready), 32'd1);
      idle(4);

      // Scoreboard set/clear and same-edge set-wins
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
`ifdef WB_SCOREBOARD_EN
      check("sb_set_const", bus.busy_mask, 32'h00000200);
`endif
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef WB_SCOREBOARD_EN
      check("sb_clr_const", bus.busy_mask, 32'h00000000);
`endif
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h98);
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9);
`ifdef WB_SCOREBOARD_EN
      check("sb_setwins_const", bus.busy_mask, 32'h00000200);
`endif
      idle(2);

      // Randomized traffic with phases of heavy and light pipe load
      for (int i = 0; i < 800; i++) begin
         int   pv_pct;
         logic rr;
         pv_pct = ((i / 100) % 2 == 0) ? 90 : 40;
         rr     = ($urandom_range(0, 299) == 0);
         cycle(rr,
               $urandom_range(0, 99) < pv_pct,
               ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom),
               $urandom,
               $urandom_range(0, 1) == 1,
               ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom),
               $urandom,
               $urandom_range(0, 4) == 0,
               5'($urandom));
      end
      idle(8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Write-back arbiter feeding the CPU register file's single write port (reg_write / write_addr / write_data).
- Merges two result sources:
  - the in-order pipeline WB stream, which never waits;
  - a long-latency unit (mul/div), which uses a valid/ready handshake.
- Long-unit results are buffered in a small FIFO and slotted into idle write-back cycles.
- Raises a stall request upstream when the buffer is full or has starved too long.

Parameters:
- FIFO_DEPTH, 4, long-unit result buffer entries; power of two, at least 2.
- STARVE_LIMIT, 8, consecutive blocked cycles with a non-empty FIFO before stall_req is forced.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- pipe_valid  input  1  pipeline WB result valid this cycle
- pipe_addr  input  5  pipeline destination register
- pipe_data  input  32  pipeline result
- lu_valid  input  1  long-unit result valid
- lu_ready  output  1  FIFO can accept; equals !full
- lu_addr  input  5  long-unit destination register
- lu_data  input  32  long-unit result
- lu_issue  input  1  long op issued this cycle (scoreboard set)
- lu_issue_addr  input  5  destination of the issued long op
- stall_req  output  1  upstream must hold pipe_valid=0 next cycle
- busy_mask  output  32  registers with an outstanding long-unit write
- reg_write  output  1  register-file write enable (registered)
- write_addr  output  5  register-file write address (registered)
- write_data  output  32  register-file write data (registered)

Behaviour:
- Reset state: all outputs 0; FIFO empty; starve counter 0; busy_mask 0.
- Output register: reloaded every edge; reg_write=0 in any cycle with no selected write.
- Pipe path: a pipe write with pipe_addr!=0 in cycle N appears on the outputs in cycle N+1. Latency 1.
- Long-unit path: the FIFO pushes at the edge where lu_valid && lu_ready. The earliest output is 2 cycles after that handshake cycle; the FIFO is never bypassed.
- Pipe slot use:
  - The pipe owns the slot whenever pipe_valid && pipe_addr!=0.
  - Otherwise the FIFO head is popped into the output register, if the FIFO is non-empty.
- Register 0 filtering: writes to register 0 from either source are dropped and never emitted. A long-unit entry with address 0 is still popped, producing a cycle with reg_write=0.
- lu_ready: from registered occupancy only. When full, lu_ready=0 even if a pop happens the same cycle.
- Simultaneous push and pop when non-full: both occur; occupancy unchanged. Pointers wrap modulo FIFO_DEPTH.
- Starve counter:
  - Increments each cycle the FIFO is non-empty and the pipe owns the slot.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- stall_req = full || (starve counter == STARVE_LIMIT). Combinational from registered state only.
- Protocol violation (pipe_valid && pipe_addr!=0 while stall_req=1): the pipe still wins and the FIFO waits. No data is lost or corrupted.
- Ordering: FIFO entries drain strictly in order. WAW hazards between the sources are prevented upstream via busy_mask.
- Reset mid-operation: FIFO contents are discarded and the output write is cancelled on that edge.

Optional Feature:
- WB_SCOREBOARD_EN defined:
  - busy_mask[lu_issue_addr] is set at the edge where lu_issue=1 and lu_issue_addr!=0.
  - busy_mask[a] clears at the edge where a FIFO entry with address a is popped.
  - Same-edge set and clear of the same address: set wins.
- WB_SCOREBOARD_EN undefined: busy_mask is tied to 0; lu_issue and lu_issue_addr are ignored; no scoreboard flops.

Test Plan:
- Pipe only: pipe_valid=1, addr=5, data=0xDEADBEEF in cycle N -> cycle N+1 shows reg_write=1, write_addr=5, write_data=0xDEADBEEF. A pipe write to addr 0 gives reg_write=0.
- Idle slot: lu write addr=7, data=0x12345678 handshaken in cycle N, pipe idle -> reg_write=1, write_addr=7 in cycle N+2.
- Fill FIFO: 4 lu pushes while the pipe writes every cycle -> lu_ready=0 and stall_req=1 after the 4th push. Pipe goes idle -> entries drain in push order, one per cycle; lu_ready returns to 1 after the first pop.
- Starvation: 1 FIFO entry, pipe writes every cycle -> stall_req rises after 8 blocked cycles. One idle pipe cycle -> the entry is written, and stall_req drops the next cycle.
- Reset with 3 entries buffered and reg_write=1 -> next cycle all outputs 0, lu_ready=1; no buffered entry is ever emitted afterward.
- With WB_SCOREBOARD_EN: lu_issue addr=9 -> busy_mask=0x00000200. The matching lu result is popped -> busy_mask=0. Re-issue of addr 9 on the same edge as its pop -> bit 9 stays 1.
